// File: rtl/magnitude_peak_pkg.sv
// Shared definitions for the per-frame magnitude peak search and its comparator.
// Holds the two-state frame tracker encoding and the frame-length limit helper.
// No logic; imported by the peak search top level.
package magnitude_peak_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Longest frame accepted for a given index width.
    function automatic int unsigned max_frame_len(input int unsigned idx_size);
        return 32'd1 << idx_size;
    endfunction

endpackage

// File: rtl/magnitude_peak_cmp.sv
// Combinational a > b, signed or unsigned as selected by SIGNED_CMP.
// Latency: zero cycles (pure combinational).
// Backpressure: none; evaluates every cycle.
module magnitude_peak_cmp #(
    parameter int DATA_SIZE  = 33,
    parameter int SIGNED_CMP = 0
) (
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    output logic                 gt
);

    generate
        if (SIGNED_CMP != 0) begin : g_signed
            assign gt = $signed(a) > $signed(b);
        end else begin : g_unsigned
            assign gt = a > b;
        end
    endgenerate

endmodule

// File: rtl/magnitude_peak.sv
// Per-frame peak search: largest sample, first index of it, and frame length.
// Latency: result/err strobes one cycle after the accepting edge.
// Backpressure: none; accepts one sample per cycle whenever data_en_i is high.
module magnitude_peak
    import magnitude_peak_pkg::*;
#(
    parameter int DATA_SIZE  = 33,
    parameter int IDX_SIZE   = 12,
    parameter int SIGNED_CMP = 0
) (
    input  logic                 data_clk_i,
    input  logic                 data_rst_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 data_en_i,
    input  logic                 data_sof_i,
    input  logic                 data_eof_i,
    output logic [DATA_SIZE-1:0] peak_o,
    output logic [IDX_SIZE-1:0]  peak_idx_o,
    output logic [IDX_SIZE:0]    frame_len_o,
    output logic                 peak_en_o,
    output logic                 err_o,
    output logic                 data_rst_o,
    output logic                 data_clk_o
);

    localparam int unsigned         MAX_LEN = max_frame_len(IDX_SIZE);
    localparam logic [IDX_SIZE:0]   MAX_CNT = MAX_LEN[IDX_SIZE:0];

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   peak_q, peak_d;
    logic [IDX_SIZE-1:0]    idx_q, idx_d;
    logic [IDX_SIZE:0]      cnt_q, cnt_d;

    logic                   data_gt;
    logic                   res_vld;
    logic [DATA_SIZE-1:0]   res_peak;
    logic [IDX_SIZE-1:0]    res_idx;
    logic [IDX_SIZE:0]      res_len;
    logic                   err_d;

    assign data_rst_o = data_rst_i;
    assign data_clk_o = data_clk_i;

    magnitude_peak_cmp #(
        .DATA_SIZE  (DATA_SIZE),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp (
        .a  (data_i),
        .b  (peak_q),
        .gt (data_gt)
    );

    always_comb begin
        state_d  = state_q;
        peak_d   = peak_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        res_vld  = 1'b0;
        res_peak = peak_q;
        res_idx  = idx_q;
        res_len  = cnt_q;
        err_d    = 1'b0;

        if (data_en_i) begin
            if (data_sof_i) begin
                // A sof always restarts; an open frame is reported as aborted.
                err_d   = (state_q == ST_RUN);
                peak_d  = data_i;
                idx_d   = '0;
                cnt_d   = {{IDX_SIZE{1'b0}}, 1'b1};
                state_d = ST_RUN;
                if (data_eof_i) begin
                    res_vld  = 1'b1;
                    res_peak = data_i;
                    res_idx  = '0;
                    res_len  = {{IDX_SIZE{1'b0}}, 1'b1};
                    state_d  = ST_IDLE;
                end
            end else if (state_q == ST_RUN) begin
                // A frame already at full length cannot take another sample, eof or not.
                if (cnt_q == MAX_CNT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (data_gt) begin
                        peak_d = data_i;
                        idx_d  = cnt_q[IDX_SIZE-1:0];
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (data_eof_i) begin
                        res_vld  = 1'b1;
                        res_peak = peak_d;
                        res_idx  = idx_d;
                        res_len  = cnt_q + 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            state_q <= ST_IDLE;
            peak_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            peak_o      <= '0;
            peak_idx_o  <= '0;
            frame_len_o <= '0;
            peak_en_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            peak_en_o <= res_vld;
            err_o     <= err_d;
            if (res_vld) begin
                peak_o      <= res_peak;
                peak_idx_o  <= res_idx;
                frame_len_o <= res_len;
            end
        end
    end

endmodule

// File: tb/tb_magnitude_peak.sv
// Drives three peak-search instances (default, 3-bit index, signed compare) from one stimulus stream.
module tb_magnitude_peak;

    localparam int DW = 33;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          en, sof, eof;

    always #5 clk = ~clk;

    logic [DW-1:0] peak0, peak1, peak2;
    logic [11:0]   idx0, idx2;
    logic [2:0]    idx1;
    logic [12:0]   len0, len2;
    logic [3:0]    len1;
    logic          pen0, pen1, pen2, err0, err1, err2;
    logic          rsto0, rsto1, rsto2, clko0, clko1, clko2;

    magnitude_peak #(.DATA_SIZE(DW), .IDX_SIZE(12), .SIGNED_CMP(0)) dut0 (
        .data_clk_i(clk), .data_rst_i(rst_n), .data_i(data), .data_en_i(en),
        .data_sof_i(sof), .data_eof_i(eof), .peak_o(peak0), .peak_idx_o(idx0),
        .frame_len_o(len0), .peak_en_o(pen0), .err_o(err0),
        .data_rst_o(rsto0), .data_clk_o(clko0));

    magnitude_peak #(.DATA_SIZE(DW), .IDX_SIZE(3), .SIGNED_CMP(0)) dut1 (
        .data_clk_i(clk), .data_rst_i(rst_n), .data_i(data), .data_en_i(en),
        .data_sof_i(sof), .data_eof_i(eof), .peak_o(peak1), .peak_idx_o(idx1),
        .frame_len_o(len1), .peak_en_o(pen1), .err_o(err1),
        .data_rst_o(rsto1), .data_clk_o(clko1));

    magnitude_peak #(.DATA_SIZE(DW), .IDX_SIZE(12), .SIGNED_CMP(1)) dut2 (
        .data_clk_i(clk), .data_rst_i(rst_n), .data_i(data), .data_en_i(en),
        .data_sof_i(sof), .data_eof_i(eof), .peak_o(peak2), .peak_idx_o(idx2),
        .frame_len_o(len2), .peak_en_o(pen2), .err_o(err2),
        .data_rst_o(rsto2), .data_clk_o(clko2));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    // Reference model: remembers the whole open frame, scans it at eof.
    int            cfg_idx [3] = '{12, 3, 12};
    bit            cfg_sgn [3] = '{1'b0, 1'b0, 1'b1};
    bit            m_in    [3];
    int            m_len   [3];
    logic [DW-1:0] m_buf   [3][4097];
    logic [DW-1:0] e_peak  [3];
    int            e_idx   [3];
    int            e_len   [3];
    bit            e_en    [3];
    bit            e_err   [3];

    function automatic bit bigger(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit s);
        return s ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_in[k] = 0; m_len[k] = 0; e_peak[k] = '0;
            e_idx[k] = 0; e_len[k] = 0; e_en[k] = 0; e_err[k] = 0;
        end
    endtask

    task automatic m_close(input int k);
        int best = 0;
        for (int i = 1; i < m_len[k]; i++)
            if (bigger(m_buf[k][i], m_buf[k][best], cfg_sgn[k])) best = i;
        e_peak[k] = m_buf[k][best];
        e_idx[k]  = best;
        e_len[k]  = m_len[k];
        e_en[k]   = 1;
        m_in[k]   = 0;
    endtask

    task automatic m_step(input bit a_en, input bit a_sof, input bit a_eof, input logic [DW-1:0] d);
        for (int k = 0; k < 3; k++) begin
            int maxl = 1 << cfg_idx[k];
            e_en[k] = 0; e_err[k] = 0;
            if (a_en) begin
                if (a_sof) begin
                    e_err[k] = m_in[k];
                    m_buf[k][0] = d; m_len[k] = 1; m_in[k] = 1;
                    if (a_eof) m_close(k);
                end else if (m_in[k]) begin
                    if (m_len[k] == maxl) begin
                        e_err[k] = 1; m_in[k] = 0;
                    end else begin
                        m_buf[k][m_len[k]] = d; m_len[k]++;
                        if (a_eof) m_close(k);
                    end
                end
            end
        end
    endtask

    task automatic chk5(input string tag, input int k, input logic pen, input logic err,
                        input logic [DW-1:0] pk, input logic [63:0] ix, input logic [63:0] ln);
        chk({tag, ".peak_en"}, k, pen, e_en[k]);
        chk({tag, ".err"},     k, err, e_err[k]);
        chk({tag, ".peak"},    k, pk,  e_peak[k]);
        chk({tag, ".idx"},     k, ix,  e_idx[k]);
        chk({tag, ".len"},     k, ln,  e_len[k]);
    endtask

    task automatic check_all(input string tag);
        chk5(tag, 0, pen0, err0, peak0, idx0, len0);
        chk5(tag, 1, pen1, err1, peak1, idx1, len1);
        chk5(tag, 2, pen2, err2, peak2, idx2, len2);
    endtask

    task automatic step(input bit a_en, input bit a_sof, input bit a_eof, input logic [DW-1:0] d, input string tag);
        en = a_en; sof = a_sof; eof = a_eof; data = d;
        m_step(a_en, a_sof, a_eof, d);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    typedef struct {
        bit            en, sof, eof;
        logic [DW-1:0] d;
        bit            x_en, x_err, x_chk;
        logic [DW-1:0] x_peak;
        int            x_idx, x_len;
    } vec_t;

    function automatic vec_t v(input bit a_en, input bit a_sof, input bit a_eof, input logic [DW-1:0] d,
                               input bit xe, input bit xr, input bit xc,
                               input logic [DW-1:0] xp, input int xi, input int xl);
        vec_t r;
        r.en = a_en; r.sof = a_sof; r.eof = a_eof; r.d = d;
        r.x_en = xe; r.x_err = xr; r.x_chk = xc; r.x_peak = xp; r.x_idx = xi; r.x_len = xl;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [63:0] r;
        bit re, rs, rf;

        // 8-sample frame, then a back-to-back single-sample frame, then an aborted frame.
        tbl.push_back(v(1, 1, 0, 33'd3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 33'd9, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 33'd2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 33'd9, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 33'd1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 33'd0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 33'd4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 1, 33'd5, 1, 0, 1, 33'd9, 1, 8));
        tbl.push_back(v(1, 1, 1, 33'h1234, 1, 0, 1, 33'h1234, 0, 1));
        tbl.push_back(v(0, 1, 1, 33'd99, 0, 0, 1, 33'h1234, 0, 1));
        tbl.push_back(v(1, 1, 0, 33'd10, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 33'd20, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 33'd30, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 33'd7, 0, 1, 1, 33'h1234, 0, 1));
        tbl.push_back(v(1, 0, 0, 33'd1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 1, 33'd2, 1, 0, 1, 33'd7, 0, 3));
        tbl.push_back(v(0, 0, 0, 33'd0, 0, 0, 1, 33'd7, 0, 3));

        en = 0; sof = 0; eof = 0; data = '0;
        rst_n = 0;
        m_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("rst_fwd", 0, rsto0, 1'b0);
        chk("clk_fwd", 0, clko0, clk);
        rst_n = 1;
        #1 chk("rst_fwd_hi", 1, rsto1, 1'b1);

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].sof, tbl[i].eof, tbl[i].d, "tbl");
            chk("tbl.peak_en", 0, pen0, tbl[i].x_en);
            chk("tbl.err",     0, err0, tbl[i].x_err);
            if (tbl[i].x_chk) begin
                chk("tbl.peak", 0, peak0, tbl[i].x_peak);
                chk("tbl.idx",  0, idx0,  tbl[i].x_idx);
                chk("tbl.len",  0, len0,  tbl[i].x_len);
            end
        end

        // Overflow on the 3-bit-index instance: 9th sample without eof aborts.
        step(1, 1, 0, 33'd1, "ovf");
        for (int i = 0; i < 7; i++) step(1, 0, 0, 33'(i + 2), "ovf");
        chk("ovf.no_err_yet", 1, err1, 1'b0);
        step(1, 0, 0, 33'd50, "ovf");
        chk("ovf.err", 1, err1, 1'b1);
        chk("ovf.no_result", 1, pen1, 1'b0);
        step(1, 1, 0, 33'd5, "ovf_next");
        step(1, 0, 0, 33'd6, "ovf_next");
        step(1, 0, 1, 33'd2, "ovf_next");
        chk("ovf_next.en", 1, pen1, 1'b1);
        chk("ovf_next.peak", 1, peak1, 33'd6);
        chk("ovf_next.idx", 1, idx1, 3'd1);
        chk("ovf_next.len", 1, len1, 4'd3);

        // Signed versus unsigned ordering.
        step(1, 1, 0, 33'h1_FFFF_FFFB, "sgn");
        step(1, 0, 0, 33'h1_FFFF_FFFF, "sgn");
        step(1, 0, 1, 33'h1_FFFF_FFFD, "sgn");
        chk("sgn.peak_s", 2, peak2, 33'h1_FFFF_FFFF);
        chk("sgn.idx_s",  2, idx2, 12'd1);
        chk("sgn.peak_u", 0, peak0, 33'h1_FFFF_FFFF);
        chk("sgn.idx_u",  0, idx0, 12'd1);
        step(1, 1, 0, 33'h0_FFFF_FFFF, "bnd");
        step(1, 0, 1, 33'h1_0000_0000, "bnd");
        chk("bnd.peak_u", 0, peak0, 33'h1_0000_0000);
        chk("bnd.idx_u",  0, idx0, 12'd1);
        chk("bnd.peak_s", 2, peak2, 33'h0_FFFF_FFFF);
        chk("bnd.idx_s",  2, idx2, 12'd0);

        // Reset mid-frame, then non-sof samples are ignored.
        step(1, 1, 0, 33'd50, "prerst");
        step(1, 0, 0, 33'd60, "prerst");
        en = 0; sof = 0; eof = 0;
        rst_n = 0;
        m_reset();
        #1;
        check_all("rst_mid");
        @(negedge clk);
        rst_n = 1;
        step(1, 0, 0, 33'd100, "postrst");
        step(1, 0, 1, 33'd200, "postrst");
        chk("postrst.no_result", 0, pen0, 1'b0);
        step(1, 1, 0, 33'd3, "postrst");
        step(1, 0, 0, 33'd8, "postrst");
        step(1, 0, 1, 33'd1, "postrst");
        chk("postrst.peak", 0, peak0, 33'd8);
        chk("postrst.idx",  0, idx0, 12'd1);
        chk("postrst.len",  0, len0, 13'd3);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r  = {$urandom(), $urandom()};
            re = ($urandom_range(0, 9) < 7);
            rs = ($urandom_range(0, 19) == 0);
            rf = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) r = 64'($urandom_range(0, 7));
            step(re, rs, rf, r[DW-1:0], "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
